float_copro_seq_dp: RTL
=======================

// Module: float_copro_seq_dp
// PURPOSE
//  Sequential, parametrised successor of the coprocessor arithmetic datapath.
//  Adds a start/busy/done handshake and an error flag. Add and sub finish in
//  one cycle; mul, div and rem use shared multi-cycle iterative hardware.
//  Sits between the LM32 coprocessor interface and its result register.
// PARAMETERS
//  WIDTH     32  operand/result width in bits, >= 4
//  OPCODE_W  11  opcode width in bits
// PORTS
//  clk      in   1         single clock, rising edge
//  reset_n  in   1         asynchronous reset, active low
//  start    in   1         request; accepted only when busy==0
//  opcode   in   OPCODE_W  0 add, 1 sub, 2 mul, 3 divu, 4 remu
//  op0      in   WIDTH     first operand, unsigned
//  op1      in   WIDTH     second operand, unsigned
//  busy     out  1         operation in progress; start ignored
//  done     out  1         one-cycle pulse; result/error valid
//  result   out  WIDTH     last result, held until the next done
//  error    out  1         div/rem by zero or illegal opcode; held like result
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE; busy, done, error=0; result=0;
//   operand, accumulator and counter registers=0. Reset mid-operation aborts
//   the operation with no done pulse.
//  FSM states: IDLE, ITER, FIN.
//   - Accept = start & ~busy at a rising edge; opcode/op0/op1 latched there.
//   - Inputs are don't-care after accept.
//  IDLE -> FIN on accept of:
//   - add, sub, illegal opcode (>4), or div/rem with op1==0.
//  IDLE -> ITER on accept of mul, or div/rem with op1!=0; counter := WIDTH-1.
//  ITER does one step per cycle; counter decrements.
//   - ITER -> FIN when counter==0, i.e. after exactly WIDTH steps.
//  FIN: done=1 for one cycle; result/error updated on the same edge FIN is
//   entered; FIN -> IDLE next.
//   - busy=1 in ITER and FIN, i.e. from the cycle after accept through the
//     done cycle.
//  Latency (accept edge to done-high cycle): 1 cycle single-step ops;
//   WIDTH+1 cycles for mul/div/rem.
//   - Throughput: a new start is accepted at the edge ending the done cycle? No:
//     busy=1 during done, so the earliest next accept is the cycle after done.
//  add/sub: modulo 2^WIDTH, carry/borrow discarded, error=0.
//  mul: shift-add, LSB first; result = low WIDTH bits of product; no overflow
//   flag; error=0.
//  divu/remu: restoring division, MSB first; quotient/remainder per C unsigned
//   semantics; error=0.
//  Div/rem by zero: quotient result = all-ones, remainder result = op0,
//   error=1, 1-cycle latency.
//  Illegal opcode: result=0, error=1, 1-cycle latency.
//  start while busy: ignored entirely; it is not queued.
//  result and error change only on the edge entering FIN.
// TESTING
//  1 add 32'hFFFF_FFFF + 32'h1 -> done 1 cycle after accept, result=0, error=0
//  2 mul 7*6 (WIDTH=32) -> busy 33 cycles, done at accept+33, result=42;
//    mul 32'h1_0000*32'h1_0000 -> result=0
//  3 divu 100/7 -> result=14; remu 100/7 -> result=2; each done at accept+33
//  4 divu 5/0 -> result=32'hFFFF_FFFF, error=1, done at accept+1;
//    remu 5/0 -> result=5, error=1
//  5 start held high with new operands during a mul -> ignored; result=42
//    unchanged after done; next op accepted only after busy falls
//  6 reset_n low 10 cycles into a divu -> busy=done=error=0 and result=0
//    immediately; no done pulse; new add after release correct

Source files
------------

// File: rtl/float_copro_seq_dp_if.sv
// Request/response bundle between the coprocessor front end and the datapath.
interface float_copro_seq_dp_if #(
  parameter int WIDTH    = 32,
  parameter int OPCODE_W = 11
);
  logic                start;
  logic [OPCODE_W-1:0] opcode;
  logic [WIDTH-1:0]    op0;
  logic [WIDTH-1:0]    op1;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    result;
  logic                error;

  modport master (
    output start, opcode, op0, op1,
    input  busy, done, result, error
  );

  modport slave (
    input  start, opcode, op0, op1,
    output busy, done, result, error
  );
endinterface

// File: rtl/float_copro_seq_dp.sv
// Sequential coprocessor arithmetic datapath: add/sub in one step, mul/divu/remu
// on a shared shift-and-iterate engine, with a start/busy/done handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; busy=0
// ITER  | one mul (shift-add) or div (restoring) step per cycle, WIDTH steps
// FIN   | done pulse; result/error were loaded on the edge entering FIN
module float_copro_seq_dp #(
  parameter int WIDTH    = 32,
  parameter int OPCODE_W = 11
) (
  input  logic                  clk,
  input  logic                  reset_n,
  float_copro_seq_dp_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIV, K_REM} kind_t;

  state_t           state;
  kind_t            kind;
  logic [CNT_W-1:0] cnt;
  // a_q: multiplicand (mul) or dividend/quotient shift register (div/rem)
  // b_q: multiplier (mul) or divisor (div/rem)
  // acc_q: product accumulator (mul) or partial remainder (div/rem)
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             error_q;

  logic             accept;
  logic             op_add, op_sub, op_mul, op_div, op_rem, op_illegal, op1_zero;
  logic             iterative;
  logic [WIDTH-1:0] imm_res;
  logic             imm_err;

  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;

  assign accept = bus.start & ~busy_q;

  // Opcode decode of the live request; only meaningful at the accept edge.
  always_comb begin
    op_add     = (bus.opcode == OPCODE_W'(0));
    op_sub     = (bus.opcode == OPCODE_W'(1));
    op_mul     = (bus.opcode == OPCODE_W'(2));
    op_div     = (bus.opcode == OPCODE_W'(3));
    op_rem     = (bus.opcode == OPCODE_W'(4));
    op_illegal = ~(op_add | op_sub | op_mul | op_div | op_rem);
    op1_zero   = (bus.op1 == '0);
    iterative  = op_mul | ((op_div | op_rem) & ~op1_zero);
  end

  // Results of the ops that complete straight from IDLE into FIN.
  always_comb begin
    imm_res = '0;
    imm_err = 1'b0;
    if (op_add) begin
      imm_res = bus.op0 + bus.op1;
    end else if (op_sub) begin
      imm_res = bus.op0 - bus.op1;
    end else if (op_div) begin
      imm_res = '1;
      imm_err = 1'b1;
    end else if (op_rem) begin
      imm_res = bus.op0;
      imm_err = 1'b1;
    end else if (op_illegal) begin
      imm_res = '0;
      imm_err = 1'b1;
    end
  end

  // One iteration step of either engine, computed from the current registers.
  always_comb begin
    mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);
    rem_sh      = {acc_q, a_q[WIDTH-1]};
    rem_ge      = (rem_sh >= {1'b0, b_q});
    // When rem_ge holds the difference is below b_q, so the low WIDTH bits suffice.
    div_rem_nxt = rem_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
    div_quo_nxt = {a_q[WIDTH-2:0], rem_ge};
  end

  // Control FSM, operand/iteration registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      kind     <= K_MUL;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= bus.op0;
            b_q    <= bus.op1;
            acc_q  <= '0;
            busy_q <= 1'b1;
            if (iterative) begin
              state <= ITER;
              cnt   <= CNT_W'(WIDTH - 1);
              kind  <= op_mul ? K_MUL : (op_div ? K_DIV : K_REM);
            end else begin
              state    <= FIN;
              result_q <= imm_res;
              error_q  <= imm_err;
              done_q   <= 1'b1;
            end
          end
        end
        ITER: begin
          cnt <= cnt - 1'b1;
          if (kind == K_MUL) begin
            acc_q <= mul_acc_nxt;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= div_rem_nxt;
            a_q   <= div_quo_nxt;
          end
          if (cnt == '0) begin
            state   <= FIN;
            done_q  <= 1'b1;
            error_q <= 1'b0;
            case (kind)
              K_MUL:   result_q <= mul_acc_nxt;
              K_DIV:   result_q <= div_quo_nxt;
              default: result_q <= div_rem_nxt;
            endcase
          end
        end
        FIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.error  = error_q;

endmodule
